// File: rtl/bomberman_pkg.sv
// Shared types for the bomb blast sweeper: map tile encoding, sweep FSM states and
// blast directions, plus the range clamp applied when a detonation is accepted.
package bomberman_pkg;

  typedef enum logic [1:0] {
    TILE_FREE  = 2'b00,
    TILE_WALL  = 2'b01,
    TILE_BRICK = 2'b10,
    TILE_BOMB  = 2'b11
  } tile_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CENTER,
    S_RD,
    S_EVAL,
    S_DONE
  } sweep_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int NUM_DIRS = 4;

  function automatic logic [3:0] clamp_range(input logic [3:0] r, input int unsigned max_range);
    return (32'(r) > max_range) ? 4'(max_range) : r;
  endfunction

endpackage

// File: rtl/explosion_sweeper_addr_to_rowcol.sv
// Registers the row/column of a linear tile address; loaded once when a detonation
// is accepted, so the divider result is ready by the time the first blast tile is chosen.
module addr_to_rowcol
  import bomberman_pkg::*;
#(
  parameter int NUM_ROW    = 11,
  parameter int NUM_COL    = 19,
  parameter int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL),
  parameter int ROW_W      = $clog2(NUM_ROW),
  parameter int COL_W      = $clog2(NUM_COL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ROW_W-1:0]      row_o,
  output logic [COL_W-1:0]      col_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (load_i) begin
      row_q <= ROW_W'(int'(addr_i) / NUM_COL);
      col_q <= COL_W'(int'(addr_i) % NUM_COL);
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/explosion_sweeper.sv
// Walks the cross-shaped blast of a detonated bomb over the map RAM, freeing bricks,
// streaming flame tiles and requesting chain detonations of bombs caught in the blast.
module explosion_sweeper
  import bomberman_pkg::*;
#(
  parameter  int NUM_ROW       = 11,
  parameter  int NUM_COL       = 19,
  parameter  int MAP_MEM_WIDTH = 2,
  parameter  int MAX_RANGE     = 9,
  localparam int ADDR_WIDTH    = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     explode_valid,
  output logic                     explode_ready,
  input  logic [ADDR_WIDTH-1:0]    explode_addr,
  input  logic [3:0]               explode_range,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [MAP_MEM_WIDTH-1:0] rd_data,
  output logic                     map_we,
  output logic [ADDR_WIDTH-1:0]    map_waddr,
  output logic [MAP_MEM_WIDTH-1:0] map_wdata,
  output logic                     free_we,
  output logic [ADDR_WIDTH-1:0]    free_addr,
  output logic                     flame_we,
  output logic [ADDR_WIDTH-1:0]    flame_addr,
  output logic                     chain_valid,
  output logic [ADDR_WIDTH-1:0]    chain_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(NUM_ROW);
  localparam int COL_W = $clog2(NUM_COL);
  localparam int K_W   = $clog2(MAX_RANGE + 2);

  sweep_state_t          state_q;
  dir_t                  dir_q;
  logic [K_W-1:0]        step_q;
  logic [K_W-1:0]        range_q;
  logic [ADDR_WIDTH-1:0] centre_q;
  logic [ADDR_WIDTH-1:0] tile_addr_q;

  logic [ROW_W-1:0] row_c;
  logic [COL_W-1:0] col_c;
  logic             accept;

  assign accept = (state_q == S_IDLE) && explode_valid;

  addr_to_rowcol #(
    .NUM_ROW   (NUM_ROW),
    .NUM_COL   (NUM_COL),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W)
  ) u_addr_to_rowcol (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(accept),
    .addr_i(explode_addr),
    .row_o (row_c),
    .col_o (col_c)
  );

  tile_t rd_tile;
  assign rd_tile = tile_t'(rd_data[1:0]);

  // Search origin: after CENTER start at UP/k=1; after EVAL either step on or move to next direction.
  logic [2:0]     srch_dir;
  logic [K_W-1:0] srch_k;

  always_comb begin
    srch_dir = 3'd0;
    srch_k   = K_W'(1);
    if (state_q == S_EVAL) begin
      if (rd_tile == TILE_FREE) begin
        srch_dir = {1'b0, dir_q};
        srch_k   = step_q + K_W'(1);
      end else begin
        srch_dir = {1'b0, dir_q} + 3'd1;
      end
    end
  end

  logic [NUM_DIRS-1:0]   cand_ok;
  logic [K_W-1:0]        cand_k    [NUM_DIRS];
  logic [ADDR_WIDTH-1:0] cand_addr [NUM_DIRS];

  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_dir
    int row_i;
    int col_i;
    assign cand_k[gi] = (gi == int'(srch_dir)) ? srch_k : K_W'(1);
    assign row_i = int'(row_c) + ((gi == 0) ? -int'(cand_k[gi]) : (gi == 1) ? int'(cand_k[gi]) : 0);
    assign col_i = int'(col_c) + ((gi == 2) ? -int'(cand_k[gi]) : (gi == 3) ? int'(cand_k[gi]) : 0);
    assign cand_ok[gi] = (gi >= int'(srch_dir)) && (cand_k[gi] != '0) && (cand_k[gi] <= range_q)
                         && (row_i >= 0) && (row_i < NUM_ROW) && (col_i >= 0) && (col_i < NUM_COL);
    assign cand_addr[gi] = ADDR_WIDTH'(row_i * NUM_COL + col_i);
  end

  logic                  nxt_found_d;
  dir_t                  nxt_dir_d;
  logic [K_W-1:0]        nxt_k_d;
  logic [ADDR_WIDTH-1:0] nxt_addr_d;

  // Lowest-numbered usable direction wins, so exhausted/off-map directions cost no cycles.
  always_comb begin
    nxt_found_d = 1'b0;
    nxt_dir_d   = DIR_UP;
    nxt_k_d     = '0;
    nxt_addr_d  = '0;
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (cand_ok[d]) begin
        nxt_found_d = 1'b1;
        nxt_dir_d   = dir_t'(2'(d));
        nxt_k_d     = cand_k[d];
        nxt_addr_d  = cand_addr[d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_UP;
      step_q      <= '0;
      range_q     <= '0;
      centre_q    <= '0;
      tile_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (explode_valid) begin
            state_q  <= S_CENTER;
            centre_q <= explode_addr;
            range_q  <= K_W'(clamp_range(explode_range, MAX_RANGE));
          end
        end
        S_CENTER, S_EVAL: begin
          if (nxt_found_d) begin
            state_q     <= S_RD;
            dir_q       <= nxt_dir_d;
            step_q      <= nxt_k_d;
            tile_addr_q <= nxt_addr_d;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_RD:    state_q <= S_EVAL;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_center, in_eval, brick_hit, bomb_hit, eval_flame;

  assign in_center  = (state_q == S_CENTER);
  assign in_eval    = (state_q == S_EVAL);
  assign brick_hit  = in_eval && (rd_tile == TILE_BRICK);
  assign bomb_hit   = in_eval && (rd_tile == TILE_BOMB);
  assign eval_flame = in_eval && (rd_tile != TILE_WALL);

  assign explode_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rd_addr       = (state_q == S_RD) ? tile_addr_q : '0;

  assign map_we      = in_center || brick_hit;
  assign map_waddr   = in_center ? centre_q : (brick_hit ? tile_addr_q : '0);
  assign map_wdata   = MAP_MEM_WIDTH'(TILE_FREE);
  assign free_we     = brick_hit;
  assign free_addr   = brick_hit ? tile_addr_q : '0;
  assign flame_we    = in_center || eval_flame;
  assign flame_addr  = in_center ? centre_q : (eval_flame ? tile_addr_q : '0);
  assign chain_valid = bomb_hit;
  assign chain_addr  = bomb_hit ? tile_addr_q : '0;

endmodule
